rv32_instr_queue: RTL

//  Parametrised instruction queue between fetch and decode. It decouples fetch

---
 rtl/rv32_instr_queue_if.sv | 42 ++++
 rtl/rv32_instr_queue.sv | 89 ++++++++
 2 files changed

// File: rtl/rv32_instr_queue_if.sv
// Fetch-to-decode slot interface for the instruction queue.
// The master side is fetch/decode (drives slot and control); the slave side is the queue.
interface rv32_instr_queue_if #(
    parameter int unsigned DEPTH = 4
) ();
    logic                     flush_in;
    logic                     stall_in;
    logic                     valid_in;
    logic                     exception_in;
    logic [3:0]               exception_cause_in;
    logic                     branch_predicted_taken_in;
    logic [31:0]              pc_in;
    logic [31:0]              instr_in;

    logic                     ready_out;
    logic                     almost_full_out;
    logic                     full_out;
    logic                     empty_out;
    logic [$clog2(DEPTH):0]   count_out;
    logic                     valid_out;
    logic                     exception_out;
    logic [3:0]               exception_cause_out;
    logic                     branch_predicted_taken_out;
    logic [31:0]              pc_out;
    logic [31:0]              instr_out;

    modport master (
        output flush_in, stall_in, valid_in, exception_in, exception_cause_in,
               branch_predicted_taken_in, pc_in, instr_in,
        input  ready_out, almost_full_out, full_out, empty_out, count_out,
               valid_out, exception_out, exception_cause_out,
               branch_predicted_taken_out, pc_out, instr_out
    );

    modport slave (
        input  flush_in, stall_in, valid_in, exception_in, exception_cause_in,
               branch_predicted_taken_in, pc_in, instr_in,
        output ready_out, almost_full_out, full_out, empty_out, count_out,
               valid_out, exception_out, exception_cause_out,
               branch_predicted_taken_out, pc_out, instr_out
    );
endinterface

// File: rtl/rv32_instr_queue.sv
// Instruction queue between fetch and decode: circular buffer of DEPTH slots,
// strict FIFO, flush support, occupancy and almost-full throttle.
// Pointers are one bit wider than the index so full and empty differ on wrap.
module rv32_instr_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ALMOST_FULL = DEPTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    rv32_instr_queue_if.slave     bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(ALMOST_FULL);

    typedef struct packed {
        logic        valid;
        logic        exception;
        logic [3:0]  cause;
        logic        bp_taken;
        logic [31:0] pc;
        logic [31:0] instr;
    } slot_t;

    slot_t       mem [DEPTH];
    slot_t       in_slot;
    slot_t       head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // full is taken from the registered count only, so a same-cycle pop cannot open a push
    assign push = (bus.valid_in || bus.exception_in) && !full && !bus.flush_in;
    assign pop  = !empty && !bus.stall_in && !bus.flush_in;

    assign in_slot = '{
        valid:     bus.valid_in,
        exception: bus.exception_in,
        cause:     bus.exception_cause_in,
        bp_taken:  bus.branch_predicted_taken_in,
        pc:        bus.pc_in,
        instr:     bus.instr_in
    };

    // Pointer update: reset over flush over push/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Slot storage write; contents need no reset since head outputs are gated by empty
    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr[AW-1:0]] <= in_slot;
    end

    // Head slot, forced to zero when the queue is empty
    always_comb begin
        head = '0;
        if (!empty) head = mem[rd_ptr[AW-1:0]];
    end

    assign bus.ready_out                  = !full;
    assign bus.almost_full_out            = (count >= AF_CNT);
    assign bus.full_out                   = full;
    assign bus.empty_out                  = empty;
    assign bus.count_out                  = count;
    assign bus.valid_out                  = head.valid;
    assign bus.exception_out              = head.exception;
    assign bus.exception_cause_out        = head.cause;
    assign bus.branch_predicted_taken_out = head.bp_taken;
    assign bus.pc_out                     = head.pc;
    assign bus.instr_out                  = head.instr;
endmodule
